// File: rtl/sd_arbiter.sv
// sd_arbiter: shares one storage-device port (command strobes, LBA, write
// FIFO, read FIFO) between two disk-controller requesters, A and B.
// Ownership is granted round-robin and never moves while a block read or
// write is still in flight; stalled transactions are aborted after TIMEOUT.
`timescale 1ns/1ps
module sd_arbiter #(
  parameter int LBA_W       = 13,
  parameter int BLOCK_WORDS = 256,
  parameter int TIMEOUT     = 2_000_000
) (
  input  logic             clk,
  input  logic             reset_n,

  // requester A
  input  logic             a_req,
  output logic             a_gnt,
  output logic             a_abort,
  input  logic [2:0]       a_dev_sel,
  input  logic [LBA_W-1:0] a_lba,
  input  logic             a_read,
  input  logic             a_write,
  output logic             a_ready,
  input  logic [15:0]      a_write_data,
  input  logic             a_write_enable,
  output logic             a_write_full,
  output logic [15:0]      a_read_data,
  input  logic             a_read_enable,
  output logic             a_read_empty,

  // requester B
  input  logic             b_req,
  output logic             b_gnt,
  output logic             b_abort,
  input  logic [2:0]       b_dev_sel,
  input  logic [LBA_W-1:0] b_lba,
  input  logic             b_read,
  input  logic             b_write,
  output logic             b_ready,
  input  logic [15:0]      b_write_data,
  input  logic             b_write_enable,
  output logic             b_write_full,
  output logic [15:0]      b_read_data,
  input  logic             b_read_enable,
  output logic             b_read_empty,

  // storage device and FIFOs
  output logic [2:0]       sd_dev_sel,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_read,
  output logic             sd_write,
  input  logic             sd_ready,
  output logic [15:0]      sd_write_data,
  output logic             sd_write_enable,
  input  logic             sd_write_full,
  input  logic [15:0]      sd_read_data,
  output logic             sd_read_enable,
  input  logic             sd_read_empty
);

  localparam int CNT_W = $clog2(BLOCK_WORDS + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_POP  = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state;
  logic              last_b;     // 1: B held the device most recently
  logic              own_req;

  logic              pend_rd;
  logic [CNT_W-1:0]  pop_cnt;
  logic              pend_wr;
  logic              busy_seen;
  logic [TMR_W-1:0]  timer;

  logic              cmd_rd;
  logic              cmd_wr;
  logic              cmd_any;
  logic              pend_any;
  logic              counted_pop;
  logic              busy_set;
  logic              time_up;
  logic              release_ok;

  // Route the owner's command/FIFO signals to the device; idle port drives 0.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    sd_dev_sel      = '0;
    sd_lba          = '0;
    sd_read         = 1'b0;
    sd_write        = 1'b0;
    sd_write_data   = '0;
    sd_write_enable = 1'b0;
    sd_read_enable  = 1'b0;
    own_req         = 1'b0;
    if (a_gnt) begin
      sd_dev_sel      = a_dev_sel;
      sd_lba          = a_lba;
      sd_read         = a_read;
      sd_write        = a_write;
      sd_write_data   = a_write_data;
      sd_write_enable = a_write_enable;
      sd_read_enable  = a_read_enable;
      own_req         = a_req;
    end else if (b_gnt) begin
      sd_dev_sel      = b_dev_sel;
      sd_lba          = b_lba;
      sd_read         = b_read;
      sd_write        = b_write;
      sd_write_data   = b_write_data;
      sd_write_enable = b_write_enable;
      sd_read_enable  = b_read_enable;
      own_req         = b_req;
    end
  end

  // The owner sees the device directly; the other side sees a dead device.
  assign a_ready      = a_gnt & sd_ready;
  assign a_write_full = a_gnt ? sd_write_full : 1'b1;
  assign a_read_empty = a_gnt ? sd_read_empty : 1'b1;
  assign a_read_data  = a_gnt ? sd_read_data  : 16'h0000;
  assign b_ready      = b_gnt & sd_ready;
  assign b_write_full = b_gnt ? sd_write_full : 1'b1;
  assign b_read_empty = b_gnt ? sd_read_empty : 1'b1;
  assign b_read_data  = b_gnt ? sd_read_data  : 16'h0000;

  // Only strobes the device accepts (sd_ready high) start a tracked
  // transaction; the muxed strobes are already zero without a grant.
  assign cmd_rd      = sd_read  & sd_ready;
  assign cmd_wr      = sd_write & sd_ready;
  assign cmd_any     = cmd_rd | cmd_wr;
  assign pend_any    = pend_rd | pend_wr;
  assign counted_pop = pend_rd & sd_read_enable & ~sd_read_empty;
  assign busy_set    = pend_wr & ~busy_seen & ~sd_ready;
  assign time_up     = pend_any & ~cmd_any & ~counted_pop & ~busy_set &
                       (timer == LAST_TICK);
  // A strobe accepted this cycle also blocks a release.
  assign release_ok  = ~(pend_any | cmd_any);

  // Read tracking: a block read is done after BLOCK_WORDS non-empty pops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_rd <= 1'b0;
      pop_cnt <= '0;
    end else if (cmd_rd) begin
      // NOTE: state registers are always assigned with <= so every block
      // samples the pre-edge values, independent of evaluation order.
      pend_rd <= 1'b1;
      pop_cnt <= '0;
    end else if (time_up) begin
      pend_rd <= 1'b0;
      pop_cnt <= '0;
    end else if (counted_pop) begin
      if (pop_cnt == LAST_POP) begin
        pend_rd <= 1'b0;
        pop_cnt <= '0;
      end else begin
        pop_cnt <= pop_cnt + 1'b1;
      end
    end
  end

  // Write tracking: done once the device has gone busy and become ready again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_wr   <= 1'b0;
      busy_seen <= 1'b0;
    end else if (cmd_wr) begin
      pend_wr   <= 1'b1;
      busy_seen <= 1'b0;
    end else if (time_up) begin
      pend_wr   <= 1'b0;
      busy_seen <= 1'b0;
    end else if (busy_set) begin
      busy_seen <= 1'b1;
    end else if (pend_wr && busy_seen && sd_ready) begin
      pend_wr   <= 1'b0;
      busy_seen <= 1'b0;
    end
  end

  // Progress watchdog: counts idle cycles of a pending transaction and
  // raises a one-cycle abort to the owner when it expires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer   <= '0;
      a_abort <= 1'b0;
      b_abort <= 1'b0;
    end else begin
      a_abort <= time_up & a_gnt;
      b_abort <= time_up & b_gnt;
      if (!pend_any || cmd_any || counted_pop || busy_set || time_up) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Ownership FSM: round-robin grant, release only with nothing in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_gnt  <= 1'b0;
      b_gnt  <= 1'b0;
      last_b <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (a_req && (!b_req || last_b)) begin
            a_gnt <= 1'b1;
            state <= OWN;
          end else if (b_req) begin
            b_gnt <= 1'b1;
            state <= OWN;
          end
        end
        OWN: begin
          if (!own_req) begin
            if (release_ok) begin
              a_gnt  <= 1'b0;
              b_gnt  <= 1'b0;
              last_b <= b_gnt;
              state  <= IDLE;
            end else begin
              state  <= FINISH;
            end
          end
        end
        FINISH: begin
          if (release_ok) begin
            a_gnt  <= 1'b0;
            b_gnt  <= 1'b0;
            last_b <= b_gnt;
            state  <= IDLE;
          end
        end
        default: begin
          a_gnt <= 1'b0;
          b_gnt <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
